// File: rtl/room_occupancy_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : room_occupancy_tracker_if
// Purpose  : Command/event inputs and count/flag outputs of the occupancy
//            tracker, bundled with master (driver) and slave (tracker) views.
// Revision : 1.0  initial release
// ============================================================================
interface room_occupancy_tracker_if #(
  parameter int NUM_ROOMS    = 4,
  parameter int DIGITS       = 2,
  parameter int TOTAL_DIGITS = 3
);
  logic [7:0]                    Selector;
  logic [3:0]                    RoomSel;
  logic                          Increment;
  logic                          ClearAll;
  logic [NUM_ROOMS*DIGITS*4-1:0] RoomCount;
  logic [TOTAL_DIGITS*4-1:0]     TotalCount;
  logic [NUM_ROOMS-1:0]          Full;
  logic [NUM_ROOMS-1:0]          Empty;
  logic                          Accept;
  logic                          Reject;

  modport master (
    output Selector, RoomSel, Increment, ClearAll,
    input  RoomCount, TotalCount, Full, Empty, Accept, Reject
  );

  modport slave (
    input  Selector, RoomSel, Increment, ClearAll,
    output RoomCount, TotalCount, Full, Empty, Accept, Reject
  );
endinterface
`default_nettype wire

// File: rtl/room_occupancy_tracker.sv
`default_nettype none
// ============================================================================
// Module   : room_occupancy_tracker
// Purpose  : Saturating per-room BCD head-counts plus a BCD building total,
//            updated by synchronised, edge-detected entry/exit strobes.
// Revision : 1.0  initial release
// ============================================================================
module room_occupancy_tracker #(
  parameter int         NUM_ROOMS    = 4,
  parameter int         DIGITS       = 2,
  parameter int         CAPACITY     = 40,
  parameter int         TOTAL_DIGITS = 3,
  parameter logic [7:0] ADD_CODE     = 8'd4,
  parameter logic [7:0] REMOVE_CODE  = 8'd20
) (
  input  wire logic                    Clock,
  input  wire logic                    ResetN,
  room_occupancy_tracker_if.slave      bus
);

  localparam int c_CW = DIGITS * 4;
  localparam int c_TW = TOTAL_DIGITS * 4;
  localparam int c_MD = (DIGITS > TOTAL_DIGITS) ? DIGITS : TOTAL_DIGITS;
  localparam int c_MW = c_MD * 4;

  // Decimal to packed BCD, used once to build the capacity comparand
  function automatic logic [c_CW-1:0] to_bcd(input int v);
    logic [c_CW-1:0] res;
    int              t;
    res = '0;
    t   = v;
    for (int d = 0; d < DIGITS; d++) begin
      res[d*4 +: 4] = 4'(t % 10);
      t             = t / 10;
    end
    return res;
  endfunction

  // One BCD step (+1 or -1) with per-digit carry/borrow ripple; callers
  // guarantee the value never leaves its legal range, so no wrap occurs
  function automatic logic [c_MW-1:0] bcd_step(input logic [c_MW-1:0] v,
                                               input logic            dec);
    logic [c_MW-1:0] res;
    logic            cy;
    res = v;
    cy  = 1'b1;
    for (int d = 0; d < c_MD; d++) begin
      if (cy) begin
        if (!dec) begin
          if (v[d*4 +: 4] == 4'd9) begin
            res[d*4 +: 4] = 4'd0;
          end else begin
            res[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
            cy            = 1'b0;
          end
        end else begin
          if (v[d*4 +: 4] == 4'd0) begin
            res[d*4 +: 4] = 4'd9;
          end else begin
            res[d*4 +: 4] = v[d*4 +: 4] - 4'd1;
            cy            = 1'b0;
          end
        end
      end
    end
    return res;
  endfunction

  localparam logic [c_CW-1:0] c_CAP_BCD = to_bcd(CAPACITY);

  logic            r_s1, r_s2, r_s3;
  logic [c_CW-1:0] r_count [NUM_ROOMS];
  logic [c_TW-1:0] r_total;
  logic            r_accept, r_reject;

  logic            w_evt;
  logic [c_CW-1:0] w_sel_count;
  logic            w_room_ok;
  logic            w_is_add, w_is_rem;
  logic            w_do_add, w_do_rem, w_rej;

  assign w_evt = r_s2 & ~r_s3;

  // Select the addressed room's count; out-of-range rooms read as zero
  always_comb begin
    w_sel_count = '0;
    for (int r = 0; r < NUM_ROOMS; r++) begin
      if (bus.RoomSel == 4'(r)) w_sel_count = r_count[r];
    end
  end

  assign w_room_ok = ({1'b0, bus.RoomSel} < 5'(NUM_ROOMS));
  assign w_is_add  = (bus.Selector == ADD_CODE);
  assign w_is_rem  = (bus.Selector == REMOVE_CODE);
  // Counts never exceed capacity, so "not equal to capacity" means "below it"
  assign w_do_add  = w_evt & w_is_add & w_room_ok & (w_sel_count != c_CAP_BCD);
  assign w_do_rem  = w_evt & w_is_rem & w_room_ok & (w_sel_count != '0);
  assign w_rej     = w_evt & ((w_is_add & ~w_do_add) | (w_is_rem & ~w_do_rem));

  // Synchroniser, event application, clear and Accept/Reject pulses
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_s3     <= 1'b0;
      r_total  <= '0;
      r_accept <= 1'b0;
      r_reject <= 1'b0;
      for (int r = 0; r < NUM_ROOMS; r++) r_count[r] <= '0;
    end else begin
      r_s1     <= bus.Increment;
      r_s2     <= r_s1;
      r_s3     <= r_s2;
      r_accept <= 1'b0;
      r_reject <= 1'b0;
      if (bus.ClearAll) begin
        // Clear wins; a coincident event is consumed silently
        r_total <= '0;
        for (int r = 0; r < NUM_ROOMS; r++) r_count[r] <= '0;
      end else if (w_do_add | w_do_rem) begin
        for (int r = 0; r < NUM_ROOMS; r++) begin
          if (bus.RoomSel == 4'(r)) begin
            r_count[r] <= c_CW'(bcd_step(c_MW'(r_count[r]), w_do_rem));
          end
        end
        r_total  <= c_TW'(bcd_step(c_MW'(r_total), w_do_rem));
        r_accept <= 1'b1;
      end else if (w_rej) begin
        r_reject <= 1'b1;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_ROOMS; g++) begin : g_room
      assign bus.RoomCount[g*c_CW +: c_CW] = r_count[g];
      assign bus.Full[g]                   = (r_count[g] == c_CAP_BCD);
      assign bus.Empty[g]                  = (r_count[g] == '0);
    end
  endgenerate

  assign bus.TotalCount = r_total;
  assign bus.Accept     = r_accept;
  assign bus.Reject     = r_reject;

endmodule
`default_nettype wire

// File: tb/tb_room_occupancy_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_room_occupancy_tracker
// Purpose  : Directed, table-driven self-checking bench for the tracker.
// Revision : 1.0  initial release
// ============================================================================
module tb_room_occupancy_tracker;

  localparam logic [7:0] c_ADD = 8'd4;
  localparam logic [7:0] c_REM = 8'd20;

  logic Clock;
  logic ResetN;
  int   n_checks;
  int   n_err;

  room_occupancy_tracker_if #(.NUM_ROOMS(4), .DIGITS(2), .TOTAL_DIGITS(3)) bus ();

  room_occupancy_tracker #(
    .NUM_ROOMS(4), .DIGITS(2), .CAPACITY(40), .TOTAL_DIGITS(3),
    .ADD_CODE(8'd4), .REMOVE_CODE(8'd20)
  ) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0]  sel;
    logic [3:0]  room;
    int          reps;
    int          chk_room;
    logic [7:0]  exp_cnt;
    logic [11:0] exp_tot;
    int          exp_acc;
    int          exp_rej;
    logic [3:0]  exp_full;
    logic [3:0]  exp_empty;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] room_cnt(input int r);
    return bus.RoomCount[r*8 +: 8];
  endfunction

  // One Increment pulse (4 cycles high, then low); counts pulses in window
  task automatic do_event(input logic [7:0] sel, input logic [3:0] room,
                          output int acc, output int rej, output int first_at);
    acc = 0; rej = 0; first_at = -1;
    @(negedge Clock);
    bus.Selector  = sel;
    bus.RoomSel   = room;
    bus.Increment = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge Clock);
      if (bus.Accept) begin acc++; if (first_at < 0) first_at = i; end
      if (bus.Reject) begin rej++; if (first_at < 0) first_at = i; end
      if (i == 4) bus.Increment = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, rej, first_at, acc_sum, rej_sum;
    n_checks = 0;
    n_err    = 0;

    //        sel    room reps rm cnt    tot      acc rej full     empty
    tbl[0]  = '{c_ADD, 4'd2, 4,  2, 8'h05, 12'h005, 4,  0, 4'b0000, 4'b1011};
    tbl[1]  = '{c_ADD, 4'd1, 9,  1, 8'h09, 12'h014, 9,  0, 4'b0000, 4'b1001};
    tbl[2]  = '{c_ADD, 4'd1, 1,  1, 8'h10, 12'h015, 1,  0, 4'b0000, 4'b1001};
    tbl[3]  = '{c_ADD, 4'd1, 30, 1, 8'h40, 12'h045, 30, 0, 4'b0010, 4'b1001};
    tbl[4]  = '{c_ADD, 4'd1, 1,  1, 8'h40, 12'h045, 0,  1, 4'b0010, 4'b1001};
    tbl[5]  = '{c_REM, 4'd0, 1,  0, 8'h00, 12'h045, 0,  1, 4'b0010, 4'b1001};
    tbl[6]  = '{c_ADD, 4'd0, 10, 0, 8'h10, 12'h055, 10, 0, 4'b0010, 4'b1000};
    tbl[7]  = '{c_REM, 4'd0, 1,  0, 8'h09, 12'h054, 1,  0, 4'b0010, 4'b1000};
    tbl[8]  = '{c_ADD, 4'd0, 31, 0, 8'h40, 12'h085, 31, 0, 4'b0011, 4'b1000};
    tbl[9]  = '{c_ADD, 4'd2, 35, 2, 8'h40, 12'h120, 35, 0, 4'b0111, 4'b1000};
    tbl[10] = '{c_ADD, 4'd3, 40, 3, 8'h40, 12'h160, 40, 0, 4'b1111, 4'b0000};
    tbl[11] = '{c_REM, 4'd3, 1,  3, 8'h39, 12'h159, 1,  0, 4'b0111, 4'b0000};
    tbl[12] = '{8'd7,  4'd3, 1,  3, 8'h39, 12'h159, 0,  0, 4'b0111, 4'b0000};
    tbl[13] = '{c_ADD, 4'd5, 1,  3, 8'h39, 12'h159, 0,  1, 4'b0111, 4'b0000};

    bus.Selector  = 8'd0;
    bus.RoomSel   = 4'd0;
    bus.Increment = 1'b0;
    bus.ClearAll  = 1'b0;
    ResetN        = 1'b0;
    repeat (3) @(negedge Clock);
    ResetN = 1'b1;
    @(negedge Clock);

    chk("reset_roomcount", 32'(bus.RoomCount), 32'h0);
    chk("reset_total", 32'(bus.TotalCount), 32'h0);
    chk("reset_empty", 32'(bus.Empty), 32'hF);
    chk("reset_full", 32'(bus.Full), 32'h0);
    chk("reset_accept", 32'(bus.Accept), 32'h0);
    chk("reset_reject", 32'(bus.Reject), 32'h0);

    // First ADD: Accept must appear on the third sample after the rise
    do_event(c_ADD, 4'd2, acc, rej, first_at);
    chk("latency_accept_cnt", 32'(acc), 32'd1);
    chk("latency_cycle", 32'(first_at), 32'd3);
    chk("latency_reject_cnt", 32'(rej), 32'd0);

    for (int v = 0; v < 14; v++) begin
      acc_sum = 0; rej_sum = 0;
      for (int k = 0; k < tbl[v].reps; k++) begin
        do_event(tbl[v].sel, tbl[v].room, acc, rej, first_at);
        acc_sum += acc;
        rej_sum += rej;
      end
      chk($sformatf("vec%0d_room", v), 32'(room_cnt(tbl[v].chk_room)), 32'(tbl[v].exp_cnt));
      chk($sformatf("vec%0d_total", v), 32'(bus.TotalCount), 32'(tbl[v].exp_tot));
      chk($sformatf("vec%0d_accepts", v), 32'(acc_sum), 32'(tbl[v].exp_acc));
      chk($sformatf("vec%0d_rejects", v), 32'(rej_sum), 32'(tbl[v].exp_rej));
      chk($sformatf("vec%0d_full", v), 32'(bus.Full), 32'(tbl[v].exp_full));
      chk($sformatf("vec%0d_empty", v), 32'(bus.Empty), 32'(tbl[v].exp_empty));
    end

    // ClearAll coincident with an ADD event on room 3 (count 39)
    acc = 0; rej = 0;
    @(negedge Clock);
    bus.Selector  = c_ADD;
    bus.RoomSel   = 4'd3;
    bus.Increment = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge Clock);
      if (bus.Accept) acc++;
      if (bus.Reject) rej++;
      if (i == 2) bus.ClearAll = 1'b1;
      if (i == 3) bus.ClearAll = 1'b0;
      if (i == 4) bus.Increment = 1'b0;
    end
    chk("clear_pulses", 32'(acc + rej), 32'd0);
    chk("clear_roomcount", 32'(bus.RoomCount), 32'h0);
    chk("clear_total", 32'(bus.TotalCount), 32'h0);
    chk("clear_empty", 32'(bus.Empty), 32'hF);

    do_event(c_ADD, 4'd0, acc, rej, first_at);
    chk("post_clear_add", 32'(room_cnt(0)), 32'h01);

    // Reset mid-pulse: asynchronous clear, then a held-high strobe recounts
    @(negedge Clock);
    bus.Selector  = c_ADD;
    bus.RoomSel   = 4'd0;
    bus.Increment = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    #2 ResetN = 1'b0;
    #1;
    chk("async_rst_roomcount", 32'(bus.RoomCount), 32'h0);
    chk("async_rst_total", 32'(bus.TotalCount), 32'h0);
    chk("async_rst_empty", 32'(bus.Empty), 32'hF);
    chk("async_rst_accept", 32'(bus.Accept), 32'h0);
    @(negedge Clock);
    ResetN = 1'b1;
    acc = 0; rej = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge Clock);
      if (bus.Accept) acc++;
      if (bus.Reject) rej++;
      if (i == 4) bus.Increment = 1'b0;
    end
    chk("rst_release_accepts", 32'(acc), 32'd1);
    chk("rst_release_rejects", 32'(rej), 32'd0);
    chk("rst_release_room0", 32'(room_cnt(0)), 32'h01);
    chk("rst_release_total", 32'(bus.TotalCount), 32'h001);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/room_occupancy_tracker.md
# room_occupancy_tracker

Multi-room occupancy counter for the building-status display path. It keeps a saturating BCD head-count per room and a running BCD building total. Counts change on synchronised, edge-detected entry/exit pulses from the door sensors. Per-room Full/Empty flags and per-event Accept/Reject pulses feed the display mux and the alarm logic.

## Interface
- NUM_ROOMS, 4, number of independent room counters (1–16)
- DIGITS, 2, BCD digits per room count
- CAPACITY, 40, per-room maximum (decimal); must be ≤ 10^DIGITS−1
- TOTAL_DIGITS, 3, BCD digits of building total; NUM_ROOMS·CAPACITY ≤ 10^TOTAL_DIGITS−1
- ADD_CODE, 8'd4, Selector value meaning "person enters"
- REMOVE_CODE, 8'd20, Selector value meaning "person leaves"
- Clock  in  1  single system clock, rising edge
- ResetN  in  1  asynchronous, active-low reset
- Selector  in  8  command code, sampled at the update edge
- RoomSel  in  4  target room index, sampled at the update edge
- Increment  in  1  asynchronous event strobe; only its rising edge counts
- ClearAll  in  1  synchronous clear of all counts
- RoomCount  out  NUM_ROOMS·DIGITS·4  packed BCD counts; room r occupies bits [r·DIGITS·4 +: DIGITS·4], digit 0 is least significant
- TotalCount  out  TOTAL_DIGITS·4  packed BCD sum of all rooms
- Full  out  NUM_ROOMS  room count == CAPACITY
- Empty  out  NUM_ROOMS  room count == 0
- Accept  out  1  one-cycle pulse: event applied
- Reject  out  1  one-cycle pulse: event refused

## Operation
- Increment passes through a 2-flop synchroniser (s1, s2) and then a history flop s3. The event is `s2 & ~s3`, which gives exactly one event per rising edge of Increment.
- On an event, decode Selector:
  - ADD_CODE: if RoomSel < NUM_ROOMS and the count < CAPACITY, increment the room count and the total, then pulse Accept. Otherwise pulse Reject and make no change.
  - REMOVE_CODE: if RoomSel < NUM_ROOMS and the count > 0, decrement the room count and the total, then pulse Accept. Otherwise pulse Reject and make no change.
  - Any other code: ignored, with no pulse.
- BCD arithmetic is per digit.
  - Increment: a digit of 9 becomes 0 and carries into the next digit.
  - Decrement: a digit of 0 becomes 9 and borrows from the next digit.
  - No count ever wraps: saturation is enforced by the CAPACITY and zero checks before the update. Digits are never outside 0–9.
- The total is updated incrementally with the same BCD rules. It always equals the BCD sum of the room counts.
- ClearAll zeroes every room count and the total on the next edge.
  - ClearAll has priority over a coincident event. That event is dropped, with no Accept or Reject.
  - Synchroniser state is not cleared.
- Full and Empty are combinational from the registered counts.

## Timing
- All registers take reset values asynchronously when ResetN=0:
  - RoomCount = 0 and TotalCount = 0.
  - Accept = 0 and Reject = 0.
  - s1, s2, s3 = 0.
  - Empty = all ones and Full = 0.
- Latency: Increment is first sampled high at edge k. The counts, Accept and Reject update at edge k+2 and are visible during cycle k+2..k+3.
- Selector and RoomSel must be stable from the Increment rise through edge k+2.
- Increment high and low times must each be ≥ 2 Clock cycles. Shorter pulses may be lost; no further guarantee is given.
- Accept and Reject are never high together and are never high for more than one cycle per event.
- Reset asserted mid-event: the pending edge is discarded. If Increment is still high when ResetN releases, it counts as a new rising edge two cycles later.
- At most one event is processed per 3 cycles, which follows from the minimum pulse spacing.

## Test plan
- Reset, then 5 ADD events to room 2 → RoomCount room 2 = 0x05, TotalCount = 0x005, 5 Accept pulses, Empty[2]=0, all other Empty bits = 1.
- 10 ADDs to room 1 from 0x09 → the 0x09→0x10 step carries correctly. Continue to 40 → Full[1]=1. A 41st ADD → Reject pulse, room 1 stays 0x40, total unchanged.
- REMOVE on empty room 0 → Reject, count 0x00, total unchanged. ADD then REMOVE on room 0 passes through 0x10→0x09 with a correct borrow.
- Fill all 4 rooms to 40 → TotalCount = 0x160. Then one REMOVE on room 3 → TotalCount = 0x159.
- Increment rising with Selector=8'd7, then with RoomSel=5 and ADD_CODE → first: no Accept or Reject, no change; second: Reject.
- ClearAll coincident with an ADD event → all counts 0, no pulse. Then assert ResetN low mid-pulse → outputs go to reset values immediately, without waiting for a clock edge.
